// File: rtl/chime_play_ctrl.sv
// ============================================================================
// Module   : chime_play_ctrl
// Purpose  : Playback controller for the melody chime score sequencer.
//            Turns a trigger request into C_REPEAT score passes separated by
//            C_GAP_TEMPOS silent tempo pulses, and tracks sequencer progress
//            by counting tempo pulses. An abort mutes the note output until
//            the sequencer reaches the end of its current pass.
// Options  : CHIME_PLAY_RETRIG_EN - a trigger edge in PLAY or GAP restarts
//            the whole sequence from pass 0.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module chime_play_ctrl #(
    parameter int C_SCORE_LEN  = 16,
    parameter int C_REPEAT     = 2,
    parameter int C_GAP_TEMPOS = 4
) (
    input  logic       CK_i,
    input  logic       RST_i,
    input  logic       TRIG_i,
    input  logic       ABORT_i,
    input  logic       TEMPO_i,
    output logic       START_o,
    output logic       BUSY_o,
    output logic       MUTE_o,
    output logic       DONE_o,
    output logic [3:0] PASS_CTRs_o,
    output logic [2:0] STATE_o
);

    localparam int c_step_w = (C_SCORE_LEN > 1) ? $clog2(C_SCORE_LEN) : 1;
    localparam logic [c_step_w-1:0] c_step_last = c_step_w'(C_SCORE_LEN - 1);
    localparam logic [3:0]          c_pass_last = 4'(C_REPEAT - 1);
    localparam logic [7:0]          c_gap_len   = 8'(C_GAP_TEMPOS);

`ifdef CHIME_PLAY_RETRIG_EN
    localparam bit c_retrig = 1'b1;
`else
    localparam bit c_retrig = 1'b0;
`endif

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARM   = 3'd1,
        ST_PLAY  = 3'd2,
        ST_GAP   = 3'd3,
        ST_DRAIN = 3'd4
    } state_t;

    state_t              r_state;
    logic                r_trig_q;
    logic [c_step_w-1:0] r_step;
    logic [7:0]          r_gap;
    logic [3:0]          r_pass;
    logic                r_start;
    logic                r_done;
    logic                r_mute;
    logic                r_drain_wait;   // DRAIN still owes the start-latch tempo

    logic                w_trig_edge;
    logic                w_step_last;
    logic [7:0]          w_gap_next;

    // Edge detect against the registered trigger copy; step/gap limit decodes
    assign w_trig_edge = TRIG_i & ~r_trig_q;
    assign w_step_last = (r_step == c_step_last);
    assign w_gap_next  = r_gap + 8'd1;

    // Playback sequencing: priority is reset > abort > tempo > trigger edge
    always_ff @(posedge CK_i) begin
        if (RST_i) begin
            r_state      <= ST_IDLE;
            r_trig_q     <= 1'b0;
            r_step       <= '0;
            r_gap        <= '0;
            r_pass       <= '0;
            r_start      <= 1'b0;
            r_done       <= 1'b0;
            r_mute       <= 1'b0;
            r_drain_wait <= 1'b0;
        end else begin
            r_trig_q <= TRIG_i;
            r_start  <= 1'b0;
            r_done   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // Abort held in IDLE suppresses a simultaneous trigger
                    if (!ABORT_i && w_trig_edge) begin
                        r_state <= ST_ARM;
                        r_start <= 1'b1;
                        r_pass  <= '0;
                    end
                end

                ST_ARM: begin
                    if (ABORT_i) begin
                        // A tempo in this same cycle is the start latch itself
                        r_state      <= ST_DRAIN;
                        r_mute       <= 1'b1;
                        r_step       <= '0;
                        r_drain_wait <= ~TEMPO_i;
                    end else if (TEMPO_i) begin
                        r_state <= ST_PLAY;
                        r_step  <= '0;
                    end
                end

                ST_PLAY: begin
                    if (ABORT_i) begin
                        r_drain_wait <= 1'b0;
                        if (TEMPO_i && w_step_last) begin
                            // Pass ends in the abort cycle: nothing left to drain
                            r_state <= ST_IDLE;
                            r_mute  <= 1'b0;
                        end else begin
                            r_state <= ST_DRAIN;
                            r_mute  <= 1'b1;
                            if (TEMPO_i) begin
                                r_step <= r_step + 1'b1;
                            end
                        end
                    end else if (TEMPO_i) begin
                        if (w_step_last) begin
                            if (r_pass == c_pass_last) begin
                                r_state <= ST_IDLE;
                                r_done  <= 1'b1;
                            end else if (C_GAP_TEMPOS == 0) begin
                                r_state <= ST_ARM;
                                r_start <= 1'b1;
                                r_pass  <= r_pass + 4'd1;
                            end else begin
                                r_state <= ST_GAP;
                                r_gap   <= '0;
                            end
                        end else begin
                            r_step <= r_step + 1'b1;
                        end
                    end else if (c_retrig && w_trig_edge) begin
                        r_state <= ST_ARM;
                        r_start <= 1'b1;
                        r_pass  <= '0;
                    end
                end

                ST_GAP: begin
                    if (ABORT_i) begin
                        // Sequencer is already silent, so no drain is needed
                        r_state <= ST_IDLE;
                        r_mute  <= 1'b0;
                    end else if (TEMPO_i) begin
                        if (w_gap_next == c_gap_len) begin
                            r_state <= ST_ARM;
                            r_start <= 1'b1;
                            r_pass  <= r_pass + 4'd1;
                        end else begin
                            r_gap <= w_gap_next;
                        end
                    end else if (c_retrig && w_trig_edge) begin
                        r_state <= ST_ARM;
                        r_start <= 1'b1;
                        r_pass  <= '0;
                    end
                end

                ST_DRAIN: begin
                    if (TEMPO_i) begin
                        if (r_drain_wait) begin
                            r_drain_wait <= 1'b0;
                            r_step       <= '0;
                        end else if (w_step_last) begin
                            r_state <= ST_IDLE;
                            r_mute  <= 1'b0;
                        end else begin
                            r_step <= r_step + 1'b1;
                        end
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_mute  <= 1'b0;
                end
            endcase
        end
    end

    // Output mapping; BUSY is a direct decode of the state register
    assign START_o     = r_start;
    assign DONE_o      = r_done;
    assign MUTE_o      = r_mute;
    assign PASS_CTRs_o = r_pass;
    assign STATE_o     = r_state;
    assign BUSY_o      = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_chime_play_ctrl.sv
// ============================================================================
// Module   : tb_chime_play_ctrl
// Purpose  : Self-checking bench for chime_play_ctrl. Two instances run from
//            the same stimulus: default parameters, and a short score with
//            three passes and no gap. Expected outputs come from a tempo-count
//            model: after a trigger, tempo k falls at offset k mod T in pass
//            k div T, with T = 1 + C_SCORE_LEN + C_GAP_TEMPOS.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_chime_play_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0, trig = 1'b0, abort_l = 1'b0, tempo = 1'b0;

    logic       a_start, a_busy, a_mute, a_done;
    logic [3:0] a_pass;
    logic [2:0] a_state;
    logic       b_start, b_busy, b_mute, b_done;
    logic [3:0] b_pass;
    logic [2:0] b_state;

    localparam int A_LEN = 16, A_REP = 2, A_GAP = 4;
    localparam int B_LEN = 4,  B_REP = 3, B_GAP = 0;

    chime_play_ctrl #(.C_SCORE_LEN(A_LEN), .C_REPEAT(A_REP), .C_GAP_TEMPOS(A_GAP)) u_dut_a (
        .CK_i(clk), .RST_i(rst), .TRIG_i(trig), .ABORT_i(abort_l), .TEMPO_i(tempo),
        .START_o(a_start), .BUSY_o(a_busy), .MUTE_o(a_mute), .DONE_o(a_done),
        .PASS_CTRs_o(a_pass), .STATE_o(a_state));

    chime_play_ctrl #(.C_SCORE_LEN(B_LEN), .C_REPEAT(B_REP), .C_GAP_TEMPOS(B_GAP)) u_dut_b (
        .CK_i(clk), .RST_i(rst), .TRIG_i(trig), .ABORT_i(abort_l), .TEMPO_i(tempo),
        .START_o(b_start), .BUSY_o(b_busy), .MUTE_o(b_mute), .DONE_o(b_done),
        .PASS_CTRs_o(b_pass), .STATE_o(b_state));

    always #5 clk = ~clk;

    // mode: 0 idle, 1 running (ARM/PLAY/GAP by tempo offset), 2 draining
    typedef struct {
        int mode;
        int k;
        int pass;
        bit trig_q;
        bit start;
        bit done;
        bit mute;
    } mdl_t;

    mdl_t m_a, m_b;
    int   nchk = 0;
    int   nerr = 0;
`ifdef CHIME_PLAY_RETRIG_EN
    localparam bit RETRIG = 1'b1;
`else
    localparam bit RETRIG = 1'b0;
`endif

    function automatic mdl_t mdl_reset();
        mdl_t s;
        s.mode = 0; s.k = 0; s.pass = 0;
        s.trig_q = 1'b0; s.start = 1'b0; s.done = 1'b0; s.mute = 1'b0;
        return s;
    endfunction

    function automatic mdl_t mdl_step(mdl_t s, int len, int rep, int gap,
                                      bit i_rst, bit i_trig, bit i_abort, bit i_tempo);
        mdl_t n;
        bit   edge_seen;
        int   t;
        int   off;
        n = s;
        t = 1 + len + gap;
        n.start = 1'b0;
        n.done  = 1'b0;
        edge_seen = i_trig && !s.trig_q;
        n.trig_q = i_trig;
        if (i_rst) begin
            n = mdl_reset();
        end else if (s.mode == 0) begin
            if (!i_abort && edge_seen) begin
                n.mode = 1; n.k = 0; n.pass = 0; n.start = 1'b1;
            end
        end else if (s.mode == 1) begin
            off = s.k - s.pass * t;
            if (i_abort) begin
                if (off > len) begin
                    n.mode = 0; n.mute = 1'b0;
                end else begin
                    n.mode = 2; n.mute = 1'b1;
                    if (i_tempo) n.k = s.k + 1;
                    if (n.k - n.pass * t == len + 1) begin
                        n.mode = 0; n.mute = 1'b0;
                    end
                end
            end else if (i_tempo) begin
                n.k = s.k + 1;
                off = n.k - n.pass * t;
                if (off == len + 1 && n.pass == rep - 1) begin
                    n.mode = 0; n.done = 1'b1;
                end else if (off == t) begin
                    n.pass = n.pass + 1; n.start = 1'b1;
                end
            end else if (RETRIG && edge_seen && off != 0) begin
                n.k = 0; n.pass = 0; n.start = 1'b1;
            end
        end else begin
            if (i_tempo) begin
                n.k = s.k + 1;
                if (n.k - n.pass * t == len + 1) begin
                    n.mode = 0; n.mute = 1'b0;
                end
            end
        end
        return n;
    endfunction

    function automatic logic [2:0] mdl_code(mdl_t s, int len, int gap);
        int off;
        off = s.k - s.pass * (1 + len + gap);
        if (s.mode == 0) return 3'd0;
        if (s.mode == 2) return 3'd4;
        if (off == 0)    return 3'd1;
        if (off <= len)  return 3'd2;
        return 3'd3;
    endfunction

    task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0d expected=%0d at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_dut(string p, logic st, logic dn, logic mu, logic bz,
                           logic [3:0] pa, logic [2:0] sc, mdl_t m, int len, int gap);
        chk({p, ".start"}, 8'(st), 8'(m.start));
        chk({p, ".done"},  8'(dn), 8'(m.done));
        chk({p, ".mute"},  8'(mu), 8'(m.mute));
        chk({p, ".busy"},  8'(bz), 8'(m.mode != 0));
        chk({p, ".pass"},  8'(pa), 8'(m.pass));
        chk({p, ".state"}, 8'(sc), 8'(mdl_code(m, len, gap)));
    endtask

    // One clock: drive inputs, advance models, sample just after the edge
    task automatic tick(bit tp);
        @(negedge clk);
        tempo = tp;
        m_a = mdl_step(m_a, A_LEN, A_REP, A_GAP, rst, trig, abort_l, tp);
        m_b = mdl_step(m_b, B_LEN, B_REP, B_GAP, rst, trig, abort_l, tp);
        @(posedge clk);
        #1;
        chk_dut("A", a_start, a_done, a_mute, a_busy, a_pass, a_state, m_a, A_LEN, A_GAP);
        chk_dut("B", b_start, b_done, b_mute, b_busy, b_pass, b_state, m_b, B_LEN, B_GAP);
    endtask

    task automatic tempos(int n);
        for (int i = 0; i < n; i++) begin
            int idle_cycles;
            idle_cycles = $urandom_range(3, 1);
            for (int j = 0; j < idle_cycles; j++) tick(1'b0);
            tick(1'b1);
        end
    endtask

    initial begin
        m_a = mdl_reset();
        m_b = mdl_reset();

        // Reset state
        rst = 1'b1;
        repeat (3) tick(1'b0);
        rst = 1'b0;
        repeat (2) tick(1'b0);

        // Full default run: two passes with a gap, then DONE
        trig = 1'b1; tick(1'b0);
        trig = 1'b0; tick(1'b0);
        tempos(38);
        repeat (3) tick(1'b0);

        // Abort at PLAY step 5, drain to end of pass
        trig = 1'b1; tick(1'b0);
        trig = 1'b0; tick(1'b0);
        tempos(6);
        abort_l = 1'b1; tick(1'b0);
        abort_l = 1'b0;
        tempos(12);
        repeat (2) tick(1'b0);

        // Trigger edge together with abort in IDLE
        abort_l = 1'b1; trig = 1'b1; tick(1'b0);
        abort_l = 1'b0; tick(1'b0);
        trig = 1'b0; tick(1'b0);

        // Trigger edge while playing
        trig = 1'b1; tick(1'b0);
        trig = 1'b0;
        tempos(3);
        trig = 1'b1; tick(1'b0);
        trig = 1'b0;
        tempos(40);

        // Reset while in GAP, then no start without a new edge
        trig = 1'b1; tick(1'b0);
        trig = 1'b0;
        tempos(19);
        rst = 1'b1; tick(1'b0);
        rst = 1'b0;
        tempos(10);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(199, 0) == 0);
            if ($urandom_range(7, 0) == 0) trig = ~trig;
            if (abort_l) abort_l = ($urandom_range(2, 0) != 0);
            else         abort_l = ($urandom_range(39, 0) == 0);
            tick($urandom_range(2, 0) == 0);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

`default_nettype wire
